led_blink_bank: RTL and testbench

LED_BLINK_BANK -- requirements
Module: led_blink_bank

---
 rtl/led_blink_pkg.sv | 38 +++
 rtl/led_blink_chan.sv | 90 +++++++++
 rtl/led_blink_bank.sv | 57 +++++
 tb/tb_led_blink_bank.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared types for the LED blink bank: channel modes, channel config record
// and the normalisation applied to every accepted configuration.
package led_blink_pkg;

    // Config fields are carried at a fixed width; the bank zero-extends its
    // CW-bit inputs, so the unused upper bits are constant zero.
    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_CONT    = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    typedef struct packed {
        mode_e              mode;
        logic [CFG_W-1:0]   period;
        logic [CFG_W-1:0]   high;
    } chan_cfg_t;

    localparam chan_cfg_t CFG_RST = '{mode: MODE_OFF, period: '0, high: '0};

    // Reserved mode maps to OFF, period is at least 2, high never exceeds period.
    function automatic chan_cfg_t make_cfg(input logic [1:0]       mode,
                                           input logic [CFG_W-1:0] period,
                                           input logic [CFG_W-1:0] high);
        chan_cfg_t c;
        case (mode)
            2'b01:   c.mode = MODE_CONT;
            2'b10:   c.mode = MODE_ONESHOT;
            default: c.mode = MODE_OFF;
        endcase
        c.period = (period < CFG_W'(2)) ? CFG_W'(2) : period;
        c.high   = (high > c.period) ? c.period : high;
        return c;
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One blink channel: active config + counter, a one-deep shadow config that
// takes effect at the end of the running period, registered led/tick.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic      fpga_CLK_AUX,
    input  logic      fpga_NRST,
    input  logic      wr,
    input  chan_cfg_t cfg,
    output logic      pending,
    output logic      led,
    output logic      tick,
    output logic      busy
);

    chan_cfg_t         act_q, act_n;
    chan_cfg_t         sh_q, sh_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic              pend_q, pend_n;
    logic              led_q, led_n;
    logic              tick_q, tick_n;
    logic              active, wrap;

    assign active  = (act_q.mode != MODE_OFF);
    assign wrap    = active && (CFG_W'(cnt_q) == act_q.period - CFG_W'(1));
    assign pending = pend_q;
    assign led     = led_q;
    assign tick    = tick_q;
    assign busy    = active;

    // Next-state: load, count, wrap with shadow hand-over or oneshot stop.
    // A write landing exactly on the wrap edge is applied directly at that
    // wrap instead of being parked in the shadow, so it can never be stranded
    // behind a oneshot that is stopping at the same edge.
    always_comb begin
        act_n  = act_q;
        sh_n   = sh_q;
        pend_n = pend_q;
        cnt_n  = cnt_q;
        if (!active) begin
            if (wr) begin
                act_n = cfg;
                cnt_n = '0;
            end
        end else if (wrap) begin
            cnt_n = '0;
            if (pend_q) begin
                act_n  = sh_q;
                pend_n = 1'b0;
            end else if (wr) begin
                act_n = cfg;
            end else if (act_q.mode == MODE_ONESHOT) begin
                act_n.mode = MODE_OFF;
            end
        end else begin
            cnt_n = cnt_q + CW'(1);
            if (wr) begin
                sh_n   = cfg;
                pend_n = 1'b1;
            end
        end
        // Outputs are registered but computed from the next state, so they
        // line up with the cnt value held during the same cycle.
        led_n  = (act_n.mode != MODE_OFF) && (CFG_W'(cnt_n) < act_n.high);
        tick_n = (act_n.mode != MODE_OFF) &&
                 (CFG_W'(cnt_n) == act_n.period - CFG_W'(1));
    end

    // State register with asynchronous clear of everything.
    always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            act_q  <= CFG_RST;
            sh_q   <= CFG_RST;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            act_q  <= act_n;
            sh_q   <= sh_n;
            cnt_q  <= cnt_n;
            pend_q <= pend_n;
            led_q  <= led_n;
            tick_q <= tick_n;
        end
    end

endmodule

// File: rtl/led_blink_bank.sv
// Bank of independent LED blink channels behind a single valid/ready config
// port; this level only decodes the target channel and muxes cfg_ready.
module led_blink_bank
    import led_blink_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int CLK_HZ = 27_000_000,
    localparam int CW     = $clog2(CLK_HZ + 1),
    localparam int SW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            fpga_CLK_AUX,
    input  logic            fpga_NRST,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [SW-1:0]   cfg_ch,
    input  logic [CW-1:0]   cfg_period,
    input  logic [CW-1:0]   cfg_high,
    input  logic [1:0]      cfg_mode,
    output logic [NCH-1:0]  led_out,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  busy
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] wr;
    chan_cfg_t      cfg_n;

    assign cfg_n = make_cfg(cfg_mode, CFG_W'(cfg_period), CFG_W'(cfg_high));

    // Ready mux: out-of-range channels match nothing and stay ready.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (cfg_ch == SW'(i)) cfg_ready = !pending[i];
    end

    // One-hot write strobe for the accepted channel.
    always_comb begin
        wr = '0;
        for (int i = 0; i < NCH; i++)
            wr[i] = cfg_valid && cfg_ready && (cfg_ch == SW'(i));
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        led_blink_chan #(.CW(CW)) u_chan (
            .fpga_CLK_AUX (fpga_CLK_AUX),
            .fpga_NRST    (fpga_NRST),
            .wr           (wr[g]),
            .cfg          (cfg_n),
            .pending      (pending[g]),
            .led          (led_out[g]),
            .tick         (tick[g]),
            .busy         (busy[g])
        );
    end

endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank: directed scenarios plus random config traffic,
// checked against a period-pattern queue model of each channel.
module tb_led_blink_bank;

    localparam int NCH = 2;
    localparam int CLK_HZ = 16;

    logic           fpga_CLK_AUX = 1'b0;
    logic           fpga_NRST = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [0:0]     cfg_ch = '0;
    logic [4:0]     cfg_period = '0;
    logic [4:0]     cfg_high = '0;
    logic [1:0]     cfg_mode = '0;
    logic [NCH-1:0] led_out, tick, busy;

    int total = 0;
    int bad = 0;

    led_blink_bank #(.NCH(NCH), .CLK_HZ(CLK_HZ)) dut (
        .fpga_CLK_AUX (fpga_CLK_AUX),
        .fpga_NRST    (fpga_NRST),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_period   (cfg_period),
        .cfg_high     (cfg_high),
        .cfg_mode     (cfg_mode),
        .led_out      (led_out),
        .tick         (tick),
        .busy         (busy)
    );

    always #5 fpga_CLK_AUX = ~fpga_CLK_AUX;

    // Model: each running channel holds the remaining {led,tick} values of
    // its current period in a queue; an empty queue means the channel is off.
    bit [1:0] mq [NCH][$];
    bit       m_pend [NCH];
    int       c_mode [NCH], c_per [NCH], c_high [NCH];
    int       s_mode [NCH], s_per [NCH], s_high [NCH];

    function automatic void fill(int c, int mode, int per, int high);
        c_mode[c] = mode; c_per[c] = per; c_high[c] = high;
        mq[c].delete();
        if (mode != 0)
            for (int i = 0; i < per; i++) mq[c].push_back({i < high, i == per - 1});
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_pend[c] = 1'b0;
        end
    endfunction

    function automatic logic [NCH-1:0] e_led();
        logic [NCH-1:0] r = '0;
        for (int c = 0; c < NCH; c++)
            if (mq[c].size() > 0) begin
                bit [1:0] f = mq[c][0];
                r[c] = f[1];
            end
        return r;
    endfunction

    function automatic logic [NCH-1:0] e_tick();
        logic [NCH-1:0] r = '0;
        for (int c = 0; c < NCH; c++)
            if (mq[c].size() > 0) begin
                bit [1:0] f = mq[c][0];
                r[c] = f[0];
            end
        return r;
    endfunction

    function automatic logic [NCH-1:0] e_busy();
        logic [NCH-1:0] r = '0;
        for (int c = 0; c < NCH; c++) r[c] = (mq[c].size() > 0);
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs being driven.
    function automatic void model_step();
        int ch = int'(cfg_ch);
        bit acc = cfg_valid && !m_pend[ch];
        int nm = (cfg_mode == 2'd1 || cfg_mode == 2'd2) ? int'(cfg_mode) : 0;
        int np = (cfg_period < 5'd2) ? 2 : int'(cfg_period);
        int nh = (int'(cfg_high) > np) ? np : int'(cfg_high);
        for (int c = 0; c < NCH; c++) begin
            bit w = acc && (ch == c);
            if (mq[c].size() == 0) begin
                if (w) fill(c, nm, np, nh);
            end else begin
                void'(mq[c].pop_front());
                if (mq[c].size() == 0) begin
                    if (m_pend[c]) begin
                        fill(c, s_mode[c], s_per[c], s_high[c]);
                        m_pend[c] = 1'b0;
                    end else if (w) fill(c, nm, np, nh);
                    else if (c_mode[c] == 1) fill(c, 1, c_per[c], c_high[c]);
                end else if (w) begin
                    s_mode[c] = nm; s_per[c] = np; s_high[c] = nh;
                    m_pend[c] = 1'b1;
                end
            end
        end
    endfunction

    task automatic drive(input bit v, input int ch, input int mode, input int per, input int high);
        cfg_valid  = v;
        cfg_ch     = 1'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = 5'(per);
        cfg_high   = 5'(high);
    endtask

    task automatic cycle();
        @(posedge fpga_CLK_AUX);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        fpga_NRST = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_clear();
        @(posedge fpga_CLK_AUX);
        #1;
        fpga_NRST = 1'b1;
    endtask

    task automatic test_reset();
        fpga_NRST = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_clear();
        #1;
        total++; if (led_out !== 2'b00) begin bad++; $display("FAIL reset_led got %b want 00", led_out); end
        total++; if (tick !== 2'b00) begin bad++; $display("FAIL reset_tick got %b want 00", tick); end
        total++; if (busy !== 2'b00) begin bad++; $display("FAIL reset_busy got %b want 00", busy); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
        repeat (2) @(posedge fpga_CLK_AUX);
        #1;
        fpga_NRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if ({led_out, tick, busy} !== 6'b0) begin
                bad++; $display("FAIL reset_idle got %b want 000000", {led_out, tick, busy});
            end
        end
    endtask

    task automatic test_cont();
        apply_reset();
        drive(1, 0, 1, 4, 1);
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (led_out[0] !== (i % 4 == 0) || tick[0] !== (i % 4 == 3) || busy[0] !== 1'b1) begin
                bad++; $display("FAIL cont_pattern i=%0d got led=%b tick=%b busy=%b", i, led_out[0], tick[0], busy[0]);
            end
            total++;
            if (led_out !== e_led() || tick !== e_tick()) begin
                bad++; $display("FAIL cont_model i=%0d got %b/%b want %b/%b", i, led_out, tick, e_led(), e_tick());
            end
            cycle();
        end
    endtask

    task automatic test_oneshot();
        int el[6] = '{1, 1, 1, 0, 0, 0};
        int et[6] = '{0, 0, 0, 0, 1, 0};
        int eb[6] = '{1, 1, 1, 1, 1, 0};
        apply_reset();
        drive(1, 1, 2, 5, 3);
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (led_out[1] !== 1'(el[i]) || tick[1] !== 1'(et[i]) || busy[1] !== 1'(eb[i])) begin
                bad++; $display("FAIL oneshot i=%0d got led=%b tick=%b busy=%b want %0d%0d%0d",
                                i, led_out[1], tick[1], busy[1], el[i], et[i], eb[i]);
            end
            cycle();
        end
    endtask

    task automatic test_pending();
        int el[13] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        int et[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        apply_reset();
        drive(1, 0, 1, 8, 3);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(1, 0, 1, 4, 2);
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL pend_ready_before got %b want 1", cfg_ready); end
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            #1;
            total++;
            if (cfg_ready !== (i >= 5)) begin
                bad++; $display("FAIL pend_ready i=%0d got %b want %b", i, cfg_ready, (i >= 5));
            end
            total++;
            if (led_out[0] !== 1'(el[i]) || tick[0] !== 1'(et[i])) begin
                bad++; $display("FAIL pend_pattern i=%0d got %b%b want %0d%0d", i, led_out[0], tick[0], el[i], et[i]);
            end
            cycle();
        end
    endtask

    task automatic test_clamp();
        apply_reset();
        drive(1, 0, 1, 0, 0);
        cycle();
        drive(1, 1, 2, 6, 9);
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (led_out[0] !== 1'b0 || tick[0] !== (i % 2 == 0) || busy[0] !== 1'b1) begin
                bad++; $display("FAIL clamp_ch0 i=%0d got led=%b tick=%b busy=%b", i, led_out[0], tick[0], busy[0]);
            end
            total++;
            if (led_out[1] !== (i < 6) || busy[1] !== (i < 6)) begin
                bad++; $display("FAIL clamp_ch1 i=%0d got led=%b busy=%b want %b", i, led_out[1], busy[1], (i < 6));
            end
            cycle();
        end
    endtask

    task automatic test_simul_wrap();
        apply_reset();
        drive(1, 0, 1, 3, 1);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(1, 1, 1, 3, 2);
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (tick !== {2{i % 3 == 2}}) begin
                bad++; $display("FAIL simul_tick i=%0d got %b want %b", i, tick, {2{i % 3 == 2}});
            end
            cycle();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            int ch = int'($urandom_range(0, 1));
            drive($urandom_range(0, 2) == 0, ch, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
            #1;
            total++;
            if (cfg_ready !== !m_pend[ch]) begin
                bad++; $display("FAIL rand_ready n=%0d got %b want %b", n, cfg_ready, !m_pend[ch]);
            end
            cycle();
            total++;
            if (led_out !== e_led() || tick !== e_tick() || busy !== e_busy()) begin
                bad++; $display("FAIL rand_out n=%0d got %b/%b/%b want %b/%b/%b",
                                n, led_out, tick, busy, e_led(), e_tick(), e_busy());
            end
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1, 0, 1, 8, 4);
        cycle();
        drive(1, 1, 1, 5, 5);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 1, 3, 1);
        cycle();
        drive(0, 0, 0, 0, 0);
        #1;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_pending got %b want 0", cfg_ready); end
        #2;
        fpga_NRST = 1'b0;
        model_clear();
        #1;
        total++;
        if ({led_out, tick, busy} !== 6'b0 || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL mid_async got %b ready=%b want 000000 ready=1", {led_out, tick, busy}, cfg_ready);
        end
        #2;
        fpga_NRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            total++;
            if ({led_out, tick, busy} !== 6'b0 || busy !== e_busy()) begin
                bad++; $display("FAIL mid_after i=%0d got %b want 000000", i, {led_out, tick, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_cont();
        test_oneshot();
        test_pending();
        test_clamp();
        test_simul_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
